pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard/stall/flush controller for the N-stage RV32I pipeline, the next generation of the fixed two-stage hazard unit. It receives memory-busy, redirect and load-use requests from the stages and drives the PC enable, next-PC select, and per-pipeline-register stall/flush vectors. It adds three things the two-stage unit lacks: a redirect-pending FSM that holds a redirect across a busy instruction fetch, a load-use bubble counter, and saturating performance counters. Pipeline register k sits between stage k and stage k+1; stage 0 is fetch.

---
 rtl/pipeline_hazard_ctrl_if.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Request/control bundle between the pipeline stages and the hazard controller.
// The pipeline side (master) raises requests; the controller (slave) answers with stall/flush/PC controls.
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 16
);
    logic                  i_ram_busy;
    logic                  iren;
    logic                  d_ram_busy;
    logic                  dren;
    logic                  dwen;
    logic                  jump;
    logic                  mispredict;
    logic                  load_use;

    logic                  pc_en;
    logic                  npc_sel;
    logic                  redirect_hold;
    logic [NUM_STAGES-2:0] stall;
    logic [NUM_STAGES-2:0] flush;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output i_ram_busy, iren, d_ram_busy, dren, dwen, jump, mispredict, load_use,
        input  pc_en, npc_sel, redirect_hold, stall, flush, stall_cycles, flush_events
    );

    modport slave (
        input  i_ram_busy, iren, d_ram_busy, dren, dwen, jump, mispredict, load_use,
        output pc_en, npc_sel, redirect_hold, stall, flush, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush controller for an N-stage pipeline: prioritised data stall, redirect
// (with hold across a busy fetch), load-use bubbles and saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES      = 4,
    parameter int REDIRECT_STAGE  = 2,
    parameter int MEM_STAGE       = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input logic                   CLK,
    input logic                   nRST,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int NREG = NUM_STAGES - 1;

    typedef enum logic [1:0] {IDLE, LU_STALL, REDIRECT_WAIT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        lu_cnt, lu_cnt_nxt;
    logic              accept;
    logic              dstall, redir;
    logic              pc_en_c, npc_sel_c, hold_c;
    logic [NREG-1:0]   stall_c, flush_c;
    logic [NREG-1:0]   mem_stall_mask, mem_flush_mask, redir_flush_mask;
    logic [CNT_W-1:0]  stall_q, flush_q;

    // Per-register masks; a MEM_STAGE past the last register simply yields no flush bit.
    for (genvar k = 0; k < NREG; k++) begin : g_mask
        assign mem_stall_mask[k]   = (k < MEM_STAGE);
        assign mem_flush_mask[k]   = (k == MEM_STAGE);
        assign redir_flush_mask[k] = (k < REDIRECT_STAGE);
    end

    assign dstall = hz.d_ram_busy & (hz.dren | hz.dwen);
    assign redir  = hz.jump | hz.mispredict;

    always_comb begin
        pc_en_c    = 1'b1;
        npc_sel_c  = 1'b0;
        hold_c     = 1'b0;
        stall_c    = '0;
        flush_c    = '0;
        state_nxt  = state;
        lu_cnt_nxt = lu_cnt;
        accept     = 1'b0;

        if (dstall) begin
            // Whole front end frozen; a pending redirect keeps steering fetch.
            pc_en_c = 1'b0;
            stall_c = mem_stall_mask;
            flush_c = mem_flush_mask;
            if (state == REDIRECT_WAIT) begin
                npc_sel_c = 1'b1;
                hold_c    = 1'b1;
            end
        end else if (state == REDIRECT_WAIT) begin
            npc_sel_c = 1'b1;
            hold_c    = 1'b1;
            flush_c   = redir_flush_mask;
            if (hz.i_ram_busy) begin
                pc_en_c = 1'b0;
            end else begin
                state_nxt = IDLE;
            end
        end else if (redir) begin
            npc_sel_c  = 1'b1;
            hold_c     = 1'b1;
            flush_c    = redir_flush_mask;
            lu_cnt_nxt = 2'd0;
            accept     = 1'b1;
            if (hz.i_ram_busy) begin
                pc_en_c   = 1'b0;
                state_nxt = REDIRECT_WAIT;
            end else begin
                state_nxt = IDLE;
            end
        end else if ((state == IDLE && hz.load_use) || state == LU_STALL) begin
            pc_en_c    = 1'b0;
            stall_c[0] = 1'b1;
            flush_c[1] = 1'b1;
            if (state == IDLE) begin
                lu_cnt_nxt = 2'(LOAD_USE_CYCLES - 1);
                state_nxt  = (LOAD_USE_CYCLES > 1) ? LU_STALL : IDLE;
            end else begin
                // The bubble in which lu_cnt reaches zero is the last one.
                lu_cnt_nxt = lu_cnt - 2'd1;
                if (lu_cnt <= 2'd1) state_nxt = IDLE;
            end
        end else if (hz.i_ram_busy) begin
            pc_en_c    = 1'b0;
            flush_c[0] = 1'b1;
        end

        if (!nRST) begin
            pc_en_c   = 1'b0;
            npc_sel_c = 1'b0;
            hold_c    = 1'b0;
            stall_c   = '0;
            flush_c   = '1;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            lu_cnt <= 2'd0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_c && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (accept && flush_q != '1)   flush_q <= flush_q + 1'b1;
        end
    end

    always_comb begin
        if (nRST) assert ((stall_c & flush_c) == '0);
    end

    assign hz.pc_en         = pc_en_c;
    assign hz.npc_sel       = npc_sel_c;
    assign hz.redirect_hold = hold_c;
    assign hz.stall         = stall_c;
    assign hz.flush         = flush_c;
    assign hz.stall_cycles  = stall_q;
    assign hz.flush_events  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_USE_CYCLES=1 and =3) share stimulus; each cycle's
// expected controls and counters are queued and checked by an independent negedge monitor.
module tb_pipeline_hazard_ctrl;
    logic CLK;
    logic nRST;
    int   cyc;
    int   checks;
    int   failures;

    pipeline_hazard_ctrl_if #(.NUM_STAGES(4), .CNT_W(16)) hz0 ();
    pipeline_hazard_ctrl_if #(.NUM_STAGES(4), .CNT_W(16)) hz1 ();

    pipeline_hazard_ctrl dut (.CLK(CLK), .nRST(nRST), .hz(hz0));
    pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(3)) dut_lu3 (.CLK(CLK), .nRST(nRST), .hz(hz1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          d;
        string       nm;
        logic [8:0]  outs;   // {pc_en, npc_sel, redirect_hold, stall[2:0], flush[2:0]}
        logic [15:0] sc;
        logic [15:0] fe;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_sc[2];
    logic [15:0] m_fe[2];

    // Inputs {i_ram_busy, d_ram_busy, dren, dwen, jump, mispredict, load_use}
    localparam logic [6:0] I0    = 7'b0000000;
    localparam logic [6:0] I_IB  = 7'b1000000;
    localparam logic [6:0] I_DB  = 7'b0100000;
    localparam logic [6:0] I_DR  = 7'b0110000;
    localparam logic [6:0] I_DW  = 7'b0101000;
    localparam logic [6:0] I_DWM = 7'b0101010;
    localparam logic [6:0] I_MP  = 7'b0000010;
    localparam logic [6:0] I_JB  = 7'b1000100;
    localparam logic [6:0] I_LU  = 7'b0000001;
    localparam logic [6:0] I_LIB = 7'b1000001;
    localparam logic [6:0] I_RWD = 7'b1110000;

    // Expected {pc_en, npc_sel, hold, stall, flush, redirect_accepted}
    localparam logic [9:0] E_RST  = 10'b0_0_0_000_111_0;
    localparam logic [9:0] E_IDLE = 10'b1_0_0_000_000_0;
    localparam logic [9:0] E_ACC  = 10'b1_1_1_000_011_1;
    localparam logic [9:0] E_ACCB = 10'b0_1_1_000_011_1;
    localparam logic [9:0] E_RWB  = 10'b0_1_1_000_011_0;
    localparam logic [9:0] E_RWF  = 10'b1_1_1_000_011_0;
    localparam logic [9:0] E_DST  = 10'b0_0_0_011_100_0;
    localparam logic [9:0] E_DSRW = 10'b0_1_1_011_100_0;
    localparam logic [9:0] E_LU   = 10'b0_0_0_001_010_0;
    localparam logic [9:0] E_IB   = 10'b0_0_0_000_001_0;

    task automatic drive(input logic [6:0] in);
        {hz0.i_ram_busy, hz0.d_ram_busy, hz0.dren, hz0.dwen, hz0.jump, hz0.mispredict, hz0.load_use} = in;
        {hz1.i_ram_busy, hz1.d_ram_busy, hz1.dren, hz1.dwen, hz1.jump, hz1.mispredict, hz1.load_use} = in;
    endtask

    task automatic step(input string nm, input logic run, input logic [6:0] in,
                        input logic [9:0] e0, input logic [9:0] e1);
        exp_t       it;
        logic [9:0] e;
        @(posedge CLK);
        #1;
        nRST = run;
        drive(in);
        for (int d = 0; d < 2; d++) begin
            e = (d == 0) ? e0 : e1;
            if (!run) begin
                m_sc[d] = 16'd0;
                m_fe[d] = 16'd0;
            end
            it.cyc  = cyc;
            it.d    = d;
            it.nm   = nm;
            it.outs = e[9:1];
            it.sc   = m_sc[d];
            it.fe   = m_fe[d];
            exp_q.push_back(it);
            if (run) begin
                if (!e[9] && m_sc[d] != 16'hFFFF) m_sc[d] = m_sc[d] + 16'd1;
                if (e[0] && m_fe[d] != 16'hFFFF)  m_fe[d] = m_fe[d] + 16'd1;
            end
        end
    endtask

    task automatic same(input string nm, input logic run, input logic [6:0] in, input logic [9:0] e);
        step(nm, run, in, e, e);
    endtask

    // Monitor: every cycle the controllers present a full control word; compare it and the counters.
    always @(negedge CLK) begin
        exp_t        it;
        logic [8:0]  act;
        logic [15:0] asc, afe;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            it = exp_q.pop_front();
            if (it.d == 0) begin
                act = {hz0.pc_en, hz0.npc_sel, hz0.redirect_hold, hz0.stall, hz0.flush};
                asc = hz0.stall_cycles;
                afe = hz0.flush_events;
            end else begin
                act = {hz1.pc_en, hz1.npc_sel, hz1.redirect_hold, hz1.stall, hz1.flush};
                asc = hz1.stall_cycles;
                afe = hz1.flush_events;
            end
            checks++;
            if (act !== it.outs || it.cyc != cyc) begin
                failures++;
                $display("FAIL %s/outs dut%0d cyc=%0d got=%b want=%b (pc,npc,hold,stall,flush)",
                         it.nm, it.d, cyc, act, it.outs);
            end
            checks++;
            if (asc !== it.sc || afe !== it.fe) begin
                failures++;
                $display("FAIL %s/cnt dut%0d cyc=%0d got sc=%0d fe=%0d want sc=%0d fe=%0d",
                         it.nm, it.d, cyc, asc, afe, it.sc, it.fe);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_sc[0] = 16'd0; m_sc[1] = 16'd0;
        m_fe[0] = 16'd0; m_fe[1] = 16'd0;
        nRST = 1'b0;
        hz0.iren = 1'b1;
        hz1.iren = 1'b1;
        drive(I0);

        repeat (3) same("reset", 1'b0, I0, E_RST);
        same("release",     1'b1, I0,   E_IDLE);
        same("dbusy_noacc", 1'b1, I_DB, E_IDLE);

        same("mispr",    1'b1, I_MP, E_ACC);
        same("post_mp",  1'b1, I0,   E_IDLE);

        same("jmp_b1",   1'b1, I_JB, E_ACCB);
        same("jmp_b2",   1'b1, I_JB, E_RWB);
        same("jmp_b3",   1'b1, I_JB, E_RWB);
        same("jmp_rel",  1'b1, I0,   E_RWF);
        same("post_jmp", 1'b1, I0,   E_IDLE);

        same("dst_mp1",  1'b1, I_DWM, E_DST);
        same("dst_mp2",  1'b1, I_DWM, E_DST);
        same("dst_acc",  1'b1, I_MP,  E_ACC);
        same("dren_st",  1'b1, I_DR,  E_DST);

        same("rw_in",    1'b1, I_JB,  E_ACCB);
        same("rw_dst",   1'b1, I_RWD, E_DSRW);
        same("rw_ib",    1'b1, I_IB,  E_RWB);
        same("rw_out",   1'b1, I0,    E_RWF);
        same("ibusy",    1'b1, I_IB,  E_IB);

        step("lu_a1",    1'b1, I_LU, E_LU,   E_LU);
        step("lu_a2",    1'b1, I0,   E_IDLE, E_LU);
        step("lu_a3",    1'b1, I0,   E_IDLE, E_LU);
        same("lu_a_end", 1'b1, I0,   E_IDLE);

        same("luh1",     1'b1, I_LU, E_LU);
        same("luh2",     1'b1, I_LU, E_LU);
        same("luh3",     1'b1, I_LU, E_LU);
        same("luh_end",  1'b1, I0,   E_IDLE);

        same("lua1",     1'b1, I_LU, E_LU);
        same("lua_mp",   1'b1, I_MP, E_ACC);
        same("lua_end",  1'b1, I0,   E_IDLE);

        step("luf1",     1'b1, I_LU, E_LU,   E_LU);
        step("luf_dst",  1'b1, I_DW, E_DST,  E_DST);
        step("luf2",     1'b1, I0,   E_IDLE, E_LU);
        step("luf3",     1'b1, I0,   E_IDLE, E_LU);
        same("luf_end",  1'b1, I0,   E_IDLE);

        same("lu_ib1",   1'b1, I_LIB, E_LU);
        step("lu_ib2",   1'b1, I0,    E_IDLE, E_LU);
        step("lu_ib3",   1'b1, I0,    E_IDLE, E_LU);
        same("lu_ib_end",1'b1, I0,    E_IDLE);

        same("rrw1",     1'b1, I_JB, E_ACCB);
        same("rrw_rst",  1'b0, I_IB, E_RST);
        same("rrw_rel",  1'b1, I0,   E_IDLE);

        step("rlu1",     1'b1, I_LU, E_LU, E_LU);
        same("rlu_rst",  1'b0, I0,   E_RST);
        same("rlu_rel",  1'b1, I0,   E_IDLE);

        same("sat_rst",  1'b0, I0,   E_RST);
        repeat (65541) same("sat", 1'b1, I_IB, E_IB);
        same("sat_end",  1'b1, I0,   E_IDLE);

        @(negedge CLK);
        @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
